// File: rtl/register_file_param_pkg.sv
// Shared types for the parametrised register file: clear-engine FSM states
// and the helper that decides when the external write port owns the array.
package register_file_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  function automatic logic ext_write_allowed(clr_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/register_file_param_if.sv
// Bus between decode/writeback and the register file: two read ports,
// one write port and the bulk-clear handshake.
interface register_file_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data_a, rd_data_b, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
    output rd_data_a, rd_data_b, clr_busy, clr_done
  );
endinterface

// File: rtl/register_file_param_clear_ctrl.sv
// Bulk-clear sequencer: walks every entry once with a write strobe, then
// pulses done for one cycle before returning to idle.
module register_file_param_clear_ctrl
  import register_file_param_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_wr_allow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // Terminal compare instead of relying on wrap, so the count never cycles.
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_clr_busy = (r_state == ST_CLEAR);
  assign o_clr_done = (r_state == ST_DONE);
  assign o_clr_we   = (r_state == ST_CLEAR);
  assign o_clr_addr = r_cnt;
  assign o_wr_allow = ext_write_allowed(r_state);

endmodule

// File: rtl/register_file_param.sv
// Parametrised two-read/one-write register file with optional zero entry,
// optional write-to-read bypass and a sequential bulk-clear engine.
module register_file_param
  import register_file_param_pkg::*;
#(
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 2,
  parameter bit                ZERO_REG  = 1'b0,
  parameter bit                BYPASS    = 1'b0,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register_file_param_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_allow;
  logic              w_wr_acc;
  logic              w_clr_busy;
  logic              w_clr_done;

  register_file_param_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_req  (bus.clr_req),
    .o_clr_busy (w_clr_busy),
    .o_clr_done (w_clr_done),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_wr_allow (w_wr_allow)
  );

  assign w_wr_acc = bus.wr_en && w_wr_allow && !(ZERO_REG && (bus.wr_addr == '0));

  // Clear engine and external writes never overlap: w_wr_allow is low in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clr_we) begin
      r_mem[w_clr_addr] <= CLR_VALUE;
    end else if (w_wr_acc) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] mem_val
  );
    if (ZERO_REG && (addr == '0))
      return '0;
    else if (BYPASS && w_wr_acc && (bus.wr_addr == addr))
      return bus.wr_data;
    else
      return mem_val;
  endfunction

  assign bus.rd_data_a = rd_sel(bus.rd_addr_a, r_mem[bus.rd_addr_a]);
  assign bus.rd_data_b = rd_sel(bus.rd_addr_b, r_mem[bus.rd_addr_b]);
  assign bus.clr_busy  = w_clr_busy;
  assign bus.clr_done  = w_clr_done;

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: dut_a (4 entries, zero reg, bypass, clear to 0x3) and
// dut_b (16 entries, plain, clear to 0x5) share clock and reset.
module tb_register_file_param;

  logic clk;
  logic rst_n;

  register_file_param_if #(.DATA_W(4), .ADDR_W(2)) if_a ();
  register_file_param_if #(.DATA_W(4), .ADDR_W(4)) if_b ();

  register_file_param #(
    .DATA_W(4), .ADDR_W(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLR_VALUE(4'h3)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  register_file_param #(
    .DATA_W(4), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0), .CLR_VALUE(4'h5)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int A_RDA = 0, A_RDB = 1, A_BUSY = 2, A_DONE = 3;
  localparam int B_RDA = 4, B_RDB = 5, B_BUSY = 6, B_DONE = 7;

  function automatic logic [15:0] actual(int sig);
    case (sig)
      A_RDA:   return 16'(if_a.rd_data_a);
      A_RDB:   return 16'(if_a.rd_data_b);
      A_BUSY:  return 16'(if_a.clr_busy);
      A_DONE:  return 16'(if_a.clr_done);
      B_RDA:   return 16'(if_b.rd_data_a);
      B_RDB:   return 16'(if_b.rd_data_b);
      B_BUSY:  return 16'(if_b.clr_busy);
      B_DONE:  return 16'(if_b.clr_done);
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = q.pop_front();
      act = actual(e.sig);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic push(input int sig, input logic [15:0] v, input string n);
    exp_t e;
    e.sig  = sig;
    e.exp  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_busy_done(input logic b, input logic d, input string n);
    push(A_BUSY, 16'(b), {n, "_busy"});
    push(A_DONE, 16'(d), {n, "_done"});
  endtask

  task automatic b_busy_done(input logic b, input logic d, input string n);
    push(B_BUSY, 16'(b), {n, "_busy"});
    push(B_DONE, 16'(d), {n, "_done"});
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.rd_addr_a = '0; if_a.rd_addr_b = '0; if_a.wr_en = 1'b0;
    if_a.wr_addr = '0; if_a.wr_data = '0; if_a.clr_req = 1'b0;
    if_b.rd_addr_a = '0; if_b.rd_addr_b = '0; if_b.wr_en = 1'b0;
    if_b.wr_addr = '0; if_b.wr_data = '0; if_b.clr_req = 1'b0;
    #17 rst_n = 1'b1;
    step();

    // Reset state on every address of dut_a, plus dut_b's idle outputs.
    for (int i = 0; i < 4; i++) begin
      if_a.rd_addr_a = 2'(i);
      if_a.rd_addr_b = 2'(3 - i);
      push(A_RDA, 16'h0, "rst_rda");
      push(A_RDB, 16'h0, "rst_rdb");
      a_busy_done(1'b0, 1'b0, "rst_a");
      step();
    end
    b_busy_done(1'b0, 1'b0, "rst_b");

    // Plain writes, then read-back one cycle later.
    if_a.wr_en = 1'b1; if_a.wr_addr = 2'd1; if_a.wr_data = 4'hA;
    step();
    if_a.wr_addr = 2'd3; if_a.wr_data = 4'h5;
    step();
    if_a.wr_en = 1'b0; if_a.rd_addr_a = 2'd1; if_a.rd_addr_b = 2'd3;
    push(A_RDA, 16'hA, "wr_rd1");
    push(A_RDB, 16'h5, "wr_rd3");
    step();

    // Bypass: same-cycle write visible on the matching read port only.
    if_a.wr_en = 1'b1; if_a.wr_addr = 2'd2; if_a.wr_data = 4'hC;
    if_a.rd_addr_a = 2'd2; if_a.rd_addr_b = 2'd3;
    push(A_RDA, 16'hC, "bypass_rda");
    push(A_RDB, 16'h5, "bypass_other");
    step();
    if_a.wr_en = 1'b0;
    push(A_RDA, 16'hC, "bypass_landed");
    step();

    // Zero register: write to entry 0 discarded and never bypassed.
    if_a.wr_en = 1'b1; if_a.wr_addr = 2'd0; if_a.wr_data = 4'hF;
    if_a.rd_addr_a = 2'd0; if_a.rd_addr_b = 2'd0;
    push(A_RDA, 16'h0, "zero_same_cycle");
    push(A_RDB, 16'h0, "zero_same_cycle_b");
    step();
    if_a.wr_en = 1'b0;
    push(A_RDA, 16'h0, "zero_after");
    step();

    // Fill with 0x9 (entry 0 dropped by the zero register).
    for (int i = 0; i < 4; i++) begin
      if_a.wr_en = 1'b1; if_a.wr_addr = 2'(i); if_a.wr_data = 4'h9;
      step();
    end
    if_a.wr_en = 1'b0;

    // Clear: clr_req sampled at edge k.
    if_a.clr_req = 1'b1; if_a.rd_addr_a = 2'd1; if_a.rd_addr_b = 2'd3;
    push(A_RDA, 16'h9, "fill_1");
    push(A_RDB, 16'h9, "fill_3");
    a_busy_done(1'b0, 1'b0, "clr_k");
    step();
    // cycle k+1: write to 1 issued here must be dropped at edge k+2, no bypass
    if_a.clr_req = 1'b0;
    if_a.wr_en = 1'b1; if_a.wr_addr = 2'd1; if_a.wr_data = 4'h7;
    if_a.rd_addr_a = 2'd0; if_a.rd_addr_b = 2'd1;
    a_busy_done(1'b1, 1'b0, "clr_k1");
    push(A_RDA, 16'h0, "clr_k1_zero");
    push(A_RDB, 16'h9, "clr_k1_nobypass");
    step();
    if_a.wr_en = 1'b0; if_a.rd_addr_a = 2'd2;
    a_busy_done(1'b1, 1'b0, "clr_k2");
    push(A_RDA, 16'h9, "clr_k2_e2");
    push(A_RDB, 16'h9, "clr_k2_e1");
    step();
    a_busy_done(1'b1, 1'b0, "clr_k3");
    push(A_RDA, 16'h9, "clr_k3_e2");
    push(A_RDB, 16'h3, "clr_k3_e1_dropped");
    step();
    if_a.rd_addr_b = 2'd3;
    a_busy_done(1'b1, 1'b0, "clr_k4");
    push(A_RDA, 16'h3, "clr_k4_e2");
    push(A_RDB, 16'h9, "clr_k4_e3");
    step();
    // cycle k+5: done pulse, write accepted and bypassed
    if_a.wr_en = 1'b1; if_a.wr_addr = 2'd1; if_a.wr_data = 4'h7;
    if_a.rd_addr_a = 2'd1;
    a_busy_done(1'b0, 1'b1, "clr_k5");
    push(A_RDA, 16'h7, "clr_k5_bypass");
    push(A_RDB, 16'h3, "clr_k5_e3");
    step();
    if_a.wr_en = 1'b0; if_a.rd_addr_b = 2'd2;
    a_busy_done(1'b0, 1'b0, "clr_k6");
    push(A_RDA, 16'h7, "clr_k6_e1");
    push(A_RDB, 16'h3, "clr_k6_e2");
    step();

    // dut_b: entry 0 is ordinary, no bypass.
    if_b.wr_en = 1'b1; if_b.wr_addr = 4'd0; if_b.wr_data = 4'hA;
    step();
    if_b.wr_addr = 4'd4; if_b.wr_data = 4'h6;
    if_b.rd_addr_a = 4'd4; if_b.rd_addr_b = 4'd0;
    push(B_RDA, 16'h0, "b_nobypass");
    push(B_RDB, 16'hA, "b_entry0");
    step();
    if_b.wr_en = 1'b0;
    push(B_RDA, 16'h6, "b_wr4");
    step();

    // dut_b clear with clr_req held high: 17 cycles to done, then restart.
    if_b.clr_req = 1'b1;
    b_busy_done(1'b0, 1'b0, "b_k");
    step();
    for (int c = 1; c <= 16; c++) begin
      b_busy_done(1'b1, 1'b0, "b_busy");
      step();
    end
    b_busy_done(1'b0, 1'b1, "b_k17");
    push(B_RDA, 16'h5, "b_clr_e4");
    push(B_RDB, 16'h5, "b_clr_e0");
    step();
    b_busy_done(1'b0, 1'b0, "b_k18_idle");
    step();
    if_b.clr_req = 1'b0;
    b_busy_done(1'b1, 1'b0, "b_restart");
    step();
    for (int c = 2; c <= 16; c++) begin
      b_busy_done(1'b1, 1'b0, "b_busy2");
      step();
    end
    b_busy_done(1'b0, 1'b1, "b_done2");
    step();

    // Reset during a dut_a clear at cycle k+2.
    if_a.clr_req = 1'b1;
    step();
    if_a.clr_req = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    if_a.rd_addr_a = 2'd1; if_a.rd_addr_b = 2'd3;
    if_b.rd_addr_a = 4'd0;
    a_busy_done(1'b0, 1'b0, "rstmid");
    push(A_RDA, 16'h0, "rstmid_e1");
    push(A_RDB, 16'h0, "rstmid_e3");
    push(B_RDA, 16'h0, "rstmid_b_e0");
    step();
    rst_n = 1'b1;
    if_a.rd_addr_a = 2'd2;
    a_busy_done(1'b0, 1'b0, "rstpost");
    push(A_RDA, 16'h0, "rstpost_e2");
    push(A_RDB, 16'h0, "rstpost_e3");
    step();
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
